// File: rtl/picorv32_bus_fabric.sv
// picorv32_bus_fabric: single-master / N-slave interconnect for the PicoRV32 native
// memory port. Mask/base address decode (lowest index wins), registered response
// path, bus-error response for unmapped addresses and a per-transaction timeout.
// Optional error capture (o_err_addr / o_err_count) is built only when the macro
// BUS_FABRIC_ERR_CAPTURE_EN is defined; otherwise those outputs are tied to zero.
module picorv32_bus_fabric #(
    parameter int unsigned                   NUM_SLAVES     = 4,
    parameter int unsigned                   ADDR_W         = 32,
    parameter int unsigned                   DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_BASE     = {32'h3000_0000, 32'h2000_0000,
                                                               32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_MASK     = {4{32'hFF00_0000}},
    parameter int unsigned                   TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0]             ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_mem_valid,
    input  logic                         i_mem_instr,
    input  logic [ADDR_W-1:0]            i_mem_addr,
    input  logic [DATA_W-1:0]            i_mem_wdata,
    input  logic [DATA_W/8-1:0]          i_mem_wstrb,
    output logic                         o_mem_ready,
    output logic [DATA_W-1:0]            o_mem_rdata,
    output logic [NUM_SLAVES-1:0]        o_s_valid,
    output logic                         o_s_instr,
    output logic [ADDR_W-1:0]            o_s_addr,
    output logic [DATA_W-1:0]            o_s_wdata,
    output logic [DATA_W/8-1:0]          o_s_wstrb,
    input  logic [NUM_SLAVES-1:0]        i_s_ready,
    input  logic [NUM_SLAVES*DATA_W-1:0] i_s_rdata,
    output logic                         o_bus_err,
    output logic [ADDR_W-1:0]            o_err_addr,
    output logic [7:0]                   o_err_count
);

    // Counter is at least one bit wide so the TIMEOUT_CYCLES == 0 build stays legal.
    localparam int unsigned   CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP, ERR} state_t;

    state_t                  state_q;
    logic [NUM_SLAVES-1:0]   sel_q;
    logic [NUM_SLAVES-1:0]   sel_d;
    logic                    hit_d;
    logic [CW-1:0]           cnt_q;
    logic                    mem_ready_q;
    logic                    bus_err_q;
    logic [DATA_W-1:0]       mem_rdata_q;
    logic                    s_instr_q;
    logic [ADDR_W-1:0]       s_addr_q;
    logic [DATA_W-1:0]       s_wdata_q;
    logic [DATA_W/8-1:0]     s_wstrb_q;
    logic [DATA_W-1:0]       s_rdata_sel;
    logic                    ready_sel;
    logic                    timeout_hit;

    // Address decode of the incoming request; first matching slot claims it.
    always_comb begin
        hit_d = 1'b0;
        sel_d = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (!hit_d && ((i_mem_addr & SLAVE_MASK[k*ADDR_W +: ADDR_W])
                           == SLAVE_BASE[k*ADDR_W +: ADDR_W])) begin
                hit_d    = 1'b1;
                sel_d[k] = 1'b1;
            end
        end
    end

    // Read-data mux driven by the registered one-hot select.
    always_comb begin
        s_rdata_sel = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q[k]) begin
                s_rdata_sel = s_rdata_sel | i_s_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign ready_sel   = |(i_s_ready & sel_q);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    // Transaction FSM with registered response strobe, error flag and read data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_rdata_q <= '0;
            s_instr_q   <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_wstrb_q   <= '0;
        end else begin
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_mem_valid) begin
                        s_instr_q <= i_mem_instr;
                        s_addr_q  <= i_mem_addr;
                        s_wdata_q <= i_mem_wdata;
                        s_wstrb_q <= i_mem_wstrb;
                        if (hit_d) begin
                            sel_q   <= sel_d;
                            cnt_q   <= '0;
                            state_q <= ACTIVE;
                        end else begin
                            mem_ready_q <= 1'b1;
                            bus_err_q   <= 1'b1;
                            mem_rdata_q <= ERR_RDATA;
                            state_q     <= ERR;
                        end
                    end
                end
                ACTIVE: begin
                    cnt_q <= cnt_q + CW'(1);
                    // Ready wins over a timeout expiring in the same cycle.
                    if (ready_sel) begin
                        mem_ready_q <= 1'b1;
                        mem_rdata_q <= s_rdata_sel;
                        state_q     <= RESP;
                    end else if (timeout_hit) begin
                        mem_ready_q <= 1'b1;
                        bus_err_q   <= 1'b1;
                        mem_rdata_q <= ERR_RDATA;
                        state_q     <= ERR;
                    end
                end
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_mem_ready = mem_ready_q;
    assign o_mem_rdata = mem_rdata_q;
    assign o_bus_err   = bus_err_q;
    assign o_s_valid   = (state_q == ACTIVE) ? sel_q : '0;
    assign o_s_instr   = s_instr_q;
    assign o_s_addr    = s_addr_q;
    assign o_s_wdata   = s_wdata_q;
    assign o_s_wstrb   = s_wstrb_q;

`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] err_addr_q;
    logic [7:0]        err_count_q;

    // Record the address of each error response and count errors, saturating.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else if (state_q == ERR) begin
            err_addr_q <= s_addr_q;
            if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign o_err_addr  = err_addr_q;
    assign o_err_count = err_count_q;
`else
    assign o_err_addr  = '0;
    assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_picorv32_bus_fabric.sv
// Self-checking bench for picorv32_bus_fabric: directed cases plus randomized
// transactions checked against a region-level reference model.
module tb_picorv32_bus_fabric;

    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_valid = 1'b0;
    logic         mem_instr = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic [31:0]  mem_wdata = '0;
    logic [3:0]   mem_wstrb = '0;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic [3:0]   s_valid;
    logic         s_instr;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [3:0]   s_ready = '0;
    logic [127:0] s_rdata = '0;
    logic         bus_err;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;

    int checks = 0;
    int errors = 0;

    // Reference state for the error-capture feature.
    logic [31:0] err_addr_m = '0;
    int          err_cnt_m  = 0;

    // Slave 0 covers 0x00xx_xxxx and 0x10xx_xxxx (overlapping slave 1's 0x1xxx_xxxx).
    picorv32_bus_fabric #(
        .NUM_SLAVES    (4),
        .ADDR_W        (32),
        .DATA_W        (32),
        .SLAVE_BASE    ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK    ({32'hFF00_0000, 32'hFF00_0000, 32'hF000_0000, 32'hEF00_0000}),
        .TIMEOUT_CYCLES(TMO),
        .ERR_RDATA     (32'hDEAD_BEEF)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_mem_valid(mem_valid),
        .i_mem_instr(mem_instr),
        .i_mem_addr (mem_addr),
        .i_mem_wdata(mem_wdata),
        .i_mem_wstrb(mem_wstrb),
        .o_mem_ready(mem_ready),
        .o_mem_rdata(mem_rdata),
        .o_s_valid  (s_valid),
        .o_s_instr  (s_instr),
        .o_s_addr   (s_addr),
        .o_s_wdata  (s_wdata),
        .o_s_wstrb  (s_wstrb),
        .i_s_ready  (s_ready),
        .i_s_rdata  (s_rdata),
        .o_bus_err  (bus_err),
        .o_err_addr (err_addr),
        .o_err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Which slave owns an address, reasoned from the memory map regions; -1 = unmapped.
    function automatic int exp_slave(input logic [31:0] a);
        if (a[31:24] == 8'h00 || a[31:24] == 8'h10) return 0;
        if (a[31:28] == 4'h1) return 1;
        if (a[31:24] == 8'h20) return 2;
        if (a[31:24] == 8'h30) return 3;
        return -1;
    endfunction

    task automatic note_err(input logic [31:0] a);
        err_addr_m = a;
        if (err_cnt_m < 255) err_cnt_m++;
    endtask

    task automatic chk_capture();
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
        chk("err_addr", err_addr, err_addr_m);
        chk("err_count", err_count, err_cnt_m);
`else
        chk("err_addr_tied", err_addr, 0);
        chk("err_count_tied", err_count, 0);
`endif
    endtask

    // One master transaction. lat = ACTIVE cycle index on which the slave answers
    // (>= TMO means never). drop = master releases valid after the first ACTIVE cycle.
    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input logic ins, input int lat, input bit drop);
        int          e;
        bit          to;
        logic [31:0] rd [4];
        e = exp_slave(a);
        for (int k = 0; k < 4; k++) rd[k] = $urandom;
        s_rdata   = {rd[3], rd[2], rd[1], rd[0]};
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        mem_instr = ins;
        s_ready   = 4'($urandom);   // ready while IDLE must be ignored
        @(posedge clk); #1;
        s_ready = '0;
        if (e < 0) begin
            chk("err_ready", mem_ready, 1);
            chk("err_flag", bus_err, 1);
            chk("err_rdata", mem_rdata, 32'hDEAD_BEEF);
            chk("err_svalid", s_valid, 0);
            note_err(a);
        end else begin
            to = 1'b0;
            for (int c = 0; c < 32; c++) begin
                chk("svalid", s_valid, 4'b0001 << e);
                chk("saddr", s_addr, a);
                chk("swdata", s_wdata, wd);
                chk("swstrb", s_wstrb, ws);
                chk("sinstr", s_instr, ins);
                chk("no_early_ready", mem_ready, 0);
                if (drop && c == 0) mem_valid = 1'b0;
                s_ready = 4'($urandom) & ~(4'b0001 << e);
                if (c == lat) s_ready[e] = 1'b1;
                @(posedge clk); #1;
                s_ready = '0;
                if (c == lat) break;
                if (c == TMO - 1) begin
                    to = 1'b1;
                    break;
                end
            end
            chk("resp_ready", mem_ready, 1);
            chk("resp_err", bus_err, to);
            chk("resp_svalid", s_valid, 0);
            if (to) begin
                chk("tmo_rdata", mem_rdata, 32'hDEAD_BEEF);
                note_err(a);
            end else if (ws == 4'b0000) begin
                chk("rdata", mem_rdata, rd[e]);
            end
        end
        // Response cycle: request may still be held and must not be taken again.
        s_ready = 4'($urandom);
        @(posedge clk); #1;
        s_ready = '0;
        chk("idle_ready", mem_ready, 0);
        chk("idle_err", bus_err, 0);
        chk("idle_svalid", s_valid, 0);
        mem_valid = 1'b0;
        chk_capture();
    endtask

    logic [7:0] tops [10] = '{8'h00, 8'h10, 8'h11, 8'h1F, 8'h20, 8'h30, 8'h01, 8'h50, 8'hFF, 8'h21};

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", mem_ready, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_svalid", s_valid, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_swdata", s_wdata, 0);
        chk("rst_swstrb", s_wstrb, 0);
        chk("rst_sinstr", s_instr, 0);
        chk("rst_err", bus_err, 0);
        chk_capture();
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        txn(32'h0000_0010, 32'h0, 4'b0000, 1'b1, 0, 1'b0);   // slave0 read, answer next cycle
        txn(32'h2000_0000, 32'h41, 4'b0001, 1'b0, 0, 1'b0);  // slave2 write
        txn(32'h5000_0000, 32'h0, 4'b0000, 1'b0, 0, 1'b0);   // unmapped
        txn(32'h1100_0000, 32'h0, 4'b0000, 1'b0, 99, 1'b0);  // slave1 never ready -> timeout
        txn(32'h3000_0004, 32'h0, 4'b0000, 1'b0, TMO - 1, 1'b0); // ready on last cycle wins
        txn(32'h1000_0040, 32'h0, 4'b0000, 1'b0, 2, 1'b0);   // overlap -> slave0
        txn(32'h2000_0100, 32'h0, 4'b0000, 1'b0, 3, 1'b1);   // master drops valid

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = {tops[$urandom_range(9)], 24'($urandom)};
            txn(a, $urandom, ($urandom_range(1) == 1) ? 4'($urandom) : 4'b0000,
                1'($urandom), $urandom_range(9), $urandom_range(3) == 0);
        end

        // Reset while ACTIVE on slave3
        mem_valid = 1'b1;
        mem_addr  = 32'h3000_0100;
        mem_wstrb = 4'b0000;
        @(posedge clk); #1;
        chk("pre_rst_svalid", s_valid, 4'b1000);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_svalid", s_valid, 0);
        chk("mid_rst_ready", mem_ready, 0);
        chk("mid_rst_saddr", s_addr, 0);
        rst       = 1'b0;
        mem_valid = 1'b0;
        err_addr_m = '0;
        err_cnt_m  = 0;
        @(posedge clk); #1;
        chk("post_rst_no_resp", mem_ready, 0);
        chk_capture();
        txn(32'h3000_0200, 32'h0, 4'b0000, 1'b0, 1, 1'b0);

        // Error counter saturation
        for (int n = 0; n < 300; n++) begin
            txn(32'h5000_0000 + 32'(n), 32'h0, 4'b0000, 1'b0, 0, 1'b0);
        end
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
        chk("err_count_sat", err_count, 8'hFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
